// File: rtl/burst_scheduler_if.sv
// -----------------------------------------------------------------------------
// burst_scheduler_if
// Purpose : groups the control, configuration and status signals of the
//           burst scheduler into one bundle.
// Signals : en, fault, fault_clr           - user enable and fault inputs
//           cfg_valid/cfg_ready,
//           cfg_period, cfg_ontime         - configuration handshake (us)
//           gate, burst_start,
//           fault_latched, busy            - scheduler status/outputs
// Modports: master drives inputs and observes outputs (system / bench side);
//           slave is the scheduler side.
// -----------------------------------------------------------------------------
interface burst_scheduler_if #(
   parameter int unsigned CFG_W = 16
);
   logic             en;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CFG_W-1:0] cfg_period;
   logic [CFG_W-1:0] cfg_ontime;
   logic             fault;
   logic             fault_clr;
   logic             gate;
   logic             burst_start;
   logic             fault_latched;
   logic             busy;

   modport master (
      output en, cfg_valid, cfg_period, cfg_ontime, fault, fault_clr,
      input  cfg_ready, gate, burst_start, fault_latched, busy
   );

   modport slave (
      input  en, cfg_valid, cfg_period, cfg_ontime, fault, fault_clr,
      output cfg_ready, gate, burst_start, fault_latched, busy
   );
endinterface

// File: rtl/burst_scheduler.sv
// -----------------------------------------------------------------------------
// burst_scheduler
// Purpose : burst interrupter for the coil-drive PWM. Releases the PWM (gate
//           high) for a programmed on-time once per programmed period, with a
//           hard on-time cap, a minimum off-time and a latched fault state.
//           Configuration is captured into shadow registers at any time and
//           copied into the active registers only when a burst starts.
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           bus  - burst_scheduler_if.slave (en, cfg handshake, fault inputs,
//                  gate / burst_start / fault_latched / busy outputs)
// -----------------------------------------------------------------------------
module burst_scheduler #(
   parameter int unsigned CLK_MHZ    = 50,
   parameter int unsigned CFG_W      = 16,
   parameter int unsigned ON_US_MAX  = 200,
   parameter int unsigned MIN_OFF_US = 1000
) (
   input  logic               clk,
   input  logic               rst,
   burst_scheduler_if.slave   bus
);
   localparam int unsigned PRE_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam int unsigned W     = CFG_W + 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_MHZ - 1);
   localparam logic [W-1:0]     ON_MAX   = W'(ON_US_MAX);
   localparam logic [W-1:0]     MIN_OFF  = W'(MIN_OFF_US);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FAULT} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CFG_W-1:0]  r_sh_period;
   logic [CFG_W-1:0]  r_sh_on;
   logic [W-1:0]      r_act_on;
   logic [W-1:0]      r_act_off;
   logic [PRE_W-1:0]  r_pre;
   logic [W-1:0]      r_us;
   logic              r_gate;
   logic              r_start;
   logic              r_ready;

   logic              w_tick;
   logic [W-1:0]      w_sh_on;
   logic [W-1:0]      w_sh_period;
   logic [W-1:0]      w_act_on;
   logic [W-1:0]      w_act_off;
   logic              w_on_done;
   logic              w_off_done;
   logic              w_burst_ok;
   logic              w_cfg_fire;

   assign w_tick      = (r_pre == PRE_LAST);
   assign w_sh_on     = {1'b0, r_sh_on};
   assign w_sh_period = {1'b0, r_sh_period};
   assign w_act_on    = (w_sh_on > ON_MAX) ? ON_MAX : w_sh_on;
   // Honour the programmed period only if it leaves at least the minimum
   // off-time after the (possibly clamped) on-time.
   assign w_act_off   = (w_sh_period >= (w_act_on + MIN_OFF)) ?
                        (w_sh_period - w_act_on) : MIN_OFF;

   // r_us counts completed microseconds in the current state, so the last
   // microsecond finishes on the tick where r_us + 1 reaches the target.
   assign w_on_done   = w_tick && ((r_us + W'(1)) >= r_act_on);
   assign w_off_done  = w_tick && ((r_us + W'(1)) >= r_act_off);
   assign w_burst_ok  = bus.en && (r_sh_on != '0);
   assign w_cfg_fire  = bus.cfg_valid && r_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_burst_ok) w_next = S_ON;
         S_ON:    if (w_on_done) w_next = S_OFF;
         S_OFF:   if (w_off_done) w_next = w_burst_ok ? S_ON : S_IDLE;
         S_FAULT: if (bus.fault_clr && !bus.fault) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (bus.fault && (r_state != S_FAULT)) w_next = S_FAULT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sh_period <= '0;
         r_sh_on     <= '0;
         r_act_on    <= '0;
         r_act_off   <= '0;
         r_pre       <= '0;
         r_us        <= '0;
         r_gate      <= 1'b0;
         r_start     <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         r_state <= w_next;

         // Prescaler restarts on every state entry so durations are exact.
         if (w_next != r_state) begin
            r_pre <= '0;
            r_us  <= '0;
         end else if ((r_state == S_ON) || (r_state == S_OFF)) begin
            if (w_tick) begin
               r_pre <= '0;
               r_us  <= r_us + W'(1);
            end else begin
               r_pre <= r_pre + PRE_W'(1);
            end
         end

         if (w_cfg_fire) begin
            r_sh_period <= bus.cfg_period;
            r_sh_on     <= bus.cfg_ontime;
         end

         // Active values come from the shadow contents before any same-cycle
         // configuration write.
         if ((w_next == S_ON) && (r_state != S_ON)) begin
            r_act_on  <= w_act_on;
            r_act_off <= w_act_off;
         end

         r_gate  <= (w_next == S_ON);
         r_start <= (w_next == S_ON) && (r_state != S_ON);
         r_ready <= (w_next != S_FAULT);
      end
   end

   assign bus.gate          = r_gate & ~bus.fault;
   assign bus.burst_start   = r_start & ~bus.fault;
   assign bus.fault_latched = (r_state == S_FAULT);
   assign bus.busy          = (r_state == S_ON) || (r_state == S_OFF);
   assign bus.cfg_ready     = r_ready;
endmodule

// File: tb/tb_burst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_burst_scheduler
// Purpose : self-checking bench for burst_scheduler, run with a scaled-down
//           timebase so full bursts fit in a short simulation. Expected burst
//           lengths come from the clamp / minimum-off rules computed directly.
// -----------------------------------------------------------------------------
module tb_burst_scheduler;
   localparam int M      = 2;
   localparam int CW     = 16;
   localparam int MAXU   = 20;
   localparam int MINOFF = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_scheduler_if #(.CFG_W(CW)) bus ();

   burst_scheduler #(
      .CLK_MHZ(M), .CFG_W(CW), .ON_US_MAX(MAXU), .MIN_OFF_US(MINOFF)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Expected high/low lengths in clock cycles for a burst started with the
   // given shadow configuration.
   function automatic int exp_on_cyc(input int on);
      return ((on > MAXU) ? MAXU : on) * M;
   endfunction

   function automatic int exp_off_cyc(input int per, input int on);
      int a;
      a = (on > MAXU) ? MAXU : on;
      return ((per >= a + MINOFF) ? (per - a) : MINOFF) * M;
   endfunction

   task automatic write_cfg(input int p, input int o);
      @(negedge clk);
      bus.cfg_valid  = 1'b1;
      bus.cfg_period = CW'(p);
      bus.cfg_ontime = CW'(o);
      @(negedge clk);
      bus.cfg_valid  = 1'b0;
   endtask

   task automatic wait_gate(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.gate === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Counts cycles at level lvl, starting with the current one; returns at
   // the first negedge where gate has left that level.
   task automatic count_gate(input logic lvl, input int budget, output int n);
      n = 1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.gate !== lvl) break;
         n++;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0 && bus.gate === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_total++; if (bus.gate !== 1'b0) $display("FAIL reset_gate got=%b exp=0", bus.gate); else n_pass++;
      n_total++; if (bus.burst_start !== 1'b0) $display("FAIL reset_burst_start got=%b exp=0", bus.burst_start); else n_pass++;
      n_total++; if (bus.fault_latched !== 1'b0) $display("FAIL reset_fault_latched got=%b exp=0", bus.fault_latched); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
      n_total++; if (bus.cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got=%b exp=0", bus.cfg_ready); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (bus.cfg_ready !== 1'b0) $display("FAIL ready_before_edge got=%b exp=0", bus.cfg_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.cfg_ready !== 1'b1) $display("FAIL ready_after_edge got=%b exp=1", bus.cfg_ready); else n_pass++;
   endtask

   task automatic test_basic;
      int nh, nl;
      bit ok;
      write_cfg(40, 10);
      @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      n_total++; if (bus.gate !== 1'b1) $display("FAIL start_latency_gate got=%b exp=1", bus.gate); else n_pass++;
      n_total++; if (bus.burst_start !== 1'b1) $display("FAIL start_pulse got=%b exp=1", bus.burst_start); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.burst_start !== 1'b0) $display("FAIL start_pulse_width got=%b exp=0", bus.burst_start); else n_pass++;
      count_gate(1'b1, 1000, nh);
      nh++;
      n_total++; if (nh !== exp_on_cyc(10)) $display("FAIL basic_high got=%0d exp=%0d", nh, exp_on_cyc(10)); else n_pass++;
      count_gate(1'b0, 1000, nl);
      n_total++; if (nh + nl !== 40 * M) $display("FAIL basic_period got=%0d exp=%0d", nh + nl, 40 * M); else n_pass++;
      n_total++; if (bus.burst_start !== 1'b1) $display("FAIL second_start_pulse got=%b exp=1", bus.burst_start); else n_pass++;
      bus.en = 1'b0;
      wait_idle(1000, ok);
      n_total++; if (!ok) $display("FAIL basic_idle got=timeout exp=idle"); else n_pass++;
   endtask

   task automatic test_clamp;
      int nh, nl;
      bit ok;
      write_cfg(45, 50);
      bus.en = 1'b1;
      wait_gate(1'b1, 20, ok);
      n_total++; if (!ok) $display("FAIL clamp_rise got=timeout exp=rise"); else n_pass++;
      count_gate(1'b1, 1000, nh);
      n_total++; if (nh !== MAXU * M) $display("FAIL clamp_high got=%0d exp=%0d", nh, MAXU * M); else n_pass++;
      count_gate(1'b0, 1000, nl);
      n_total++; if (nl !== MINOFF * M) $display("FAIL clamp_low got=%0d exp=%0d", nl, MINOFF * M); else n_pass++;
      bus.en = 1'b0;
      wait_idle(1000, ok);
   endtask

   task automatic test_deferred;
      int nh, nl;
      bit ok;
      write_cfg(40, 10);
      // Config write on the very cycle the burst starts: old values apply.
      @(negedge clk);
      bus.en         = 1'b1;
      bus.cfg_valid  = 1'b1;
      bus.cfg_period = CW'(40);
      bus.cfg_ontime = CW'(5);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      n_total++; if (bus.gate !== 1'b1) $display("FAIL defer_start got=%b exp=1", bus.gate); else n_pass++;
      count_gate(1'b1, 1000, nh);
      n_total++; if (nh !== exp_on_cyc(10)) $display("FAIL defer_same_cycle_high got=%0d exp=%0d", nh, exp_on_cyc(10)); else n_pass++;
      count_gate(1'b0, 1000, nl);
      n_total++; if (nl !== exp_off_cyc(40, 10)) $display("FAIL defer_same_cycle_low got=%0d exp=%0d", nl, exp_off_cyc(40, 10)); else n_pass++;
      // Now in burst with on=5; write on=8 mid-ON.
      bus.cfg_valid  = 1'b1;
      bus.cfg_ontime = CW'(8);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      count_gate(1'b1, 1000, nh);
      nh++;
      n_total++; if (nh !== exp_on_cyc(5)) $display("FAIL defer_mid_on_high got=%0d exp=%0d", nh, exp_on_cyc(5)); else n_pass++;
      count_gate(1'b0, 1000, nl);
      count_gate(1'b1, 1000, nh);
      n_total++; if (nh !== exp_on_cyc(8)) $display("FAIL defer_next_high got=%0d exp=%0d", nh, exp_on_cyc(8)); else n_pass++;
      bus.en = 1'b0;
      wait_idle(1000, ok);
   endtask

   task automatic test_fault;
      int nh;
      bit ok;
      write_cfg(40, 10);
      bus.en = 1'b1;
      wait_gate(1'b1, 20, ok);
      repeat (3) @(negedge clk);
      bus.fault = 1'b1;
      #1;
      n_total++; if (bus.gate !== 1'b0) $display("FAIL fault_comb_gate got=%b exp=0", bus.gate); else n_pass++;
      n_total++; if (bus.fault_latched !== 1'b0) $display("FAIL fault_latch_early got=%b exp=0", bus.fault_latched); else n_pass++;
      @(negedge clk);
      bus.fault = 1'b0;
      n_total++; if (bus.fault_latched !== 1'b1) $display("FAIL fault_latched got=%b exp=1", bus.fault_latched); else n_pass++;
      n_total++; if (bus.cfg_ready !== 1'b0) $display("FAIL fault_cfg_ready got=%b exp=0", bus.cfg_ready); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL fault_busy got=%b exp=0", bus.busy); else n_pass++;
      @(negedge clk);
      bus.fault     = 1'b1;
      bus.fault_clr = 1'b1;
      @(negedge clk);
      n_total++; if (bus.fault_latched !== 1'b1) $display("FAIL fault_clr_blocked got=%b exp=1", bus.fault_latched); else n_pass++;
      bus.fault = 1'b0;
      @(negedge clk);
      bus.fault_clr = 1'b0;
      n_total++; if (bus.fault_latched !== 1'b0) $display("FAIL fault_clear got=%b exp=0", bus.fault_latched); else n_pass++;
      n_total++; if (bus.gate !== 1'b0) $display("FAIL clear_idle_gate got=%b exp=0", bus.gate); else n_pass++;
      n_total++; if (bus.cfg_ready !== 1'b1) $display("FAIL clear_cfg_ready got=%b exp=1", bus.cfg_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.gate !== 1'b1) $display("FAIL resume_gate got=%b exp=1", bus.gate); else n_pass++;
      count_gate(1'b1, 1000, nh);
      n_total++; if (nh !== exp_on_cyc(10)) $display("FAIL resume_high got=%0d exp=%0d", nh, exp_on_cyc(10)); else n_pass++;
      bus.en = 1'b0;
      wait_idle(1000, ok);
   endtask

   task automatic test_en_drop;
      int nh, nb, nr;
      bit ok;
      write_cfg(40, 10);
      bus.en = 1'b1;
      wait_gate(1'b1, 20, ok);
      nh = 1;
      for (int i = 0; i < 1000; i++) begin
         if (i == 3) bus.en = 1'b0;
         @(negedge clk);
         if (bus.gate !== 1'b1) break;
         nh++;
      end
      n_total++; if (nh !== exp_on_cyc(10)) $display("FAIL en_drop_high got=%0d exp=%0d", nh, exp_on_cyc(10)); else n_pass++;
      nb = 0;
      for (int i = 0; i < 1000; i++) begin
         if (bus.busy !== 1'b1) break;
         nb++;
         @(negedge clk);
      end
      n_total++; if (nb !== exp_off_cyc(40, 10)) $display("FAIL en_drop_off got=%0d exp=%0d", nb, exp_off_cyc(40, 10)); else n_pass++;
      nr = 0;
      for (int i = 0; i < 150; i++) begin
         if (bus.gate !== 1'b0 || bus.busy !== 1'b0) nr++;
         @(negedge clk);
      end
      n_total++; if (nr !== 0) $display("FAIL en_drop_stays_idle got=%0d exp=0", nr); else n_pass++;
   endtask

   task automatic test_zero_ontime;
      int nr;
      write_cfg(40, 0);
      bus.en = 1'b1;
      nr = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.gate !== 1'b0 || bus.busy !== 1'b0) nr++;
      end
      n_total++; if (nr !== 0) $display("FAIL zero_ontime got=%0d exp=0", nr); else n_pass++;
      bus.en = 1'b0;
   endtask

   task automatic test_async_reset;
      int nh, nr;
      bit ok;
      write_cfg(40, 10);
      bus.en = 1'b1;
      wait_gate(1'b1, 20, ok);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_total++; if (bus.gate !== 1'b0) $display("FAIL async_rst_gate got=%b exp=0", bus.gate); else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL async_rst_busy got=%b exp=0", bus.busy); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      nr = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (bus.gate !== 1'b0) nr++;
      end
      n_total++; if (nr !== 0) $display("FAIL post_rst_no_burst got=%0d exp=0", nr); else n_pass++;
      write_cfg(40, 3);
      wait_gate(1'b1, 20, ok);
      n_total++; if (!ok) $display("FAIL post_rst_reconfig got=timeout exp=rise"); else n_pass++;
      count_gate(1'b1, 1000, nh);
      n_total++; if (nh !== exp_on_cyc(3)) $display("FAIL post_rst_high got=%0d exp=%0d", nh, exp_on_cyc(3)); else n_pass++;
      bus.en = 1'b0;
      wait_idle(1000, ok);
   endtask

   task automatic test_random;
      int on, per, nh, nl;
      bit ok;
      for (int k = 0; k < 8; k++) begin
         on  = int'($urandom_range(1, 30));
         per = int'($urandom_range(0, 90));
         write_cfg(per, on);
         bus.en = 1'b1;
         wait_gate(1'b1, 20, ok);
         n_total++; if (!ok) $display("FAIL rand_rise k=%0d got=timeout exp=rise", k); else n_pass++;
         n_total++; if (bus.burst_start !== 1'b1) $display("FAIL rand_start k=%0d got=%b exp=1", k, bus.burst_start); else n_pass++;
         count_gate(1'b1, 1000, nh);
         n_total++; if (nh !== exp_on_cyc(on)) $display("FAIL rand_high k=%0d on=%0d got=%0d exp=%0d", k, on, nh, exp_on_cyc(on)); else n_pass++;
         count_gate(1'b0, 1000, nl);
         n_total++; if (nl !== exp_off_cyc(per, on)) $display("FAIL rand_low k=%0d per=%0d on=%0d got=%0d exp=%0d", k, per, on, nl, exp_off_cyc(per, on)); else n_pass++;
         bus.en = 1'b0;
         wait_idle(1000, ok);
         n_total++; if (!ok) $display("FAIL rand_idle k=%0d got=timeout exp=idle", k); else n_pass++;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      bus.en         = 1'b0;
      bus.cfg_valid  = 1'b0;
      bus.cfg_period = '0;
      bus.cfg_ontime = '0;
      bus.fault      = 1'b0;
      bus.fault_clr  = 1'b0;
      test_reset;
      test_basic;
      test_clamp;
      test_deferred;
      test_fault;
      test_en_drop;
      test_zero_ontime;
      test_async_reset;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
